// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC packet field positions, one-hot direction codes and input-buffer state encodings.
package noc_pkg;

    localparam int X_DST_HI = 31;
    localparam int X_DST_LO = 28;
    localparam int Y_DST_HI = 27;
    localparam int Y_DST_LO = 24;
    localparam int X_SRC_HI = 23;
    localparam int X_SRC_LO = 20;
    localparam int Y_SRC_HI = 19;
    localparam int Y_SRC_LO = 16;
    localparam int PKT_ID_HI = 15;
    localparam int PKT_ID_LO = 6;
    localparam int MOD_ID_HI = 5;
    localparam int MOD_ID_LO = 0;

    localparam logic [4:0] DIR_LOCAL = 5'b00001;
    localparam logic [4:0] DIR_NORTH = 5'b00010;
    localparam logic [4:0] DIR_EAST  = 5'b00100;
    localparam logic [4:0] DIR_SOUTH = 5'b01000;
    localparam logic [4:0] DIR_WEST  = 5'b10000;

    typedef enum logic {WR_ACCEPT, WR_GRANT} wrState_t;
    typedef enum logic [1:0] {RD_EMPTY, RD_REQ, RD_BUBBLE} rdState_t;

endpackage

// File: rtl/local_port_buffer_if.sv
// local_port_buffer_if: injector-side and switch-side handshake bundle of the local-port input buffer.
interface local_port_buffer_if #(
    parameter int dataWidth = 32
);

    logic                 ReqUpStr;
    logic [dataWidth-1:0] PacketIn;
    logic                 GntUpStr;
    logic                 UpStrFull;
    logic                 ReqDnStr;
    logic                 GntDnStr;
    logic [dataWidth-1:0] PacketOut;
    logic [4:0]           DirReq;
    logic [15:0]          PktCount;
    logic [15:0]          FullCycles;

    modport master (
        output ReqUpStr, PacketIn, GntDnStr,
        input  GntUpStr, UpStrFull, ReqDnStr, PacketOut, DirReq, PktCount, FullCycles
    );

    modport slave (
        input  ReqUpStr, PacketIn, GntDnStr,
        output GntUpStr, UpStrFull, ReqDnStr, PacketOut, DirReq, PktCount, FullCycles
    );

endinterface

// File: rtl/xy_route_decode.sv
// xy_route_decode: XY relative-address route request from a packet's destination fields; no hop decrement.
module xy_route_decode
    import noc_pkg::*;
#(
    parameter int dataWidth = 32,
    parameter int dim = 4
) (
    input  logic [dataWidth-1:0] packet,
    output logic [4:0]           dirReq
);

    logic [dim-1:0] xDst;
    logic [dim-1:0] yDst;
    logic           unusedBits;

    assign xDst = packet[X_DST_LO +: dim];
    assign yDst = packet[Y_DST_LO +: dim];
    assign unusedBits = ^packet[X_SRC_HI:0];

    // X is resolved fully before Y; the top bit of each field is the direction
    assign dirReq = |xDst[dim-2:0] ? (xDst[dim-1] ? DIR_EAST : DIR_WEST)
                  : |yDst[dim-2:0] ? (yDst[dim-1] ? DIR_NORTH : DIR_SOUTH)
                  : DIR_LOCAL;

endmodule

// File: rtl/local_port_buffer.sv
// local_port_buffer: router local-port input buffer, a DEPTH-entry FIFO between the PE injector and the switch allocator.
// Define LPB_STATS_EN to build the saturating PktCount/FullCycles counters; otherwise both read 0.
module local_port_buffer
    import noc_pkg::*;
#(
    parameter int dataWidth = 32,
    parameter int dim = 4,
    parameter int DEPTH = 4,
    parameter int ADDR_W = 2
) (
    input logic                clk,
    input logic                reset,
    local_port_buffer_if.slave bus
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [dataWidth-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]    wrPtr;
    logic [ADDR_W-1:0]    rdPtr;
    logic [ADDR_W:0]      count;
    logic [ADDR_W:0]      countNext;
    wrState_t             wrState;
    rdState_t             rdState;
    logic                 wrEn;
    logic                 popEn;
    logic [4:0]           headDir;

    // A full buffer refuses the write even when the head is popped on the same edge
    assign wrEn = wrState == WR_ACCEPT && bus.ReqUpStr && count != FULL_COUNT;
    assign popEn = rdState == RD_REQ && bus.GntDnStr;
    assign countNext = count + (ADDR_W + 1)'(wrEn) - (ADDR_W + 1)'(popEn);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr         <= '0;
            rdPtr         <= '0;
            count         <= '0;
            wrState       <= WR_ACCEPT;
            rdState       <= RD_EMPTY;
            bus.GntUpStr  <= 1'b0;
            bus.UpStrFull <= 1'b0;
            bus.ReqDnStr  <= 1'b0;
        end else begin
            wrPtr         <= wrPtr + ADDR_W'(wrEn);
            rdPtr         <= rdPtr + ADDR_W'(popEn);
            count         <= countNext;
            bus.UpStrFull <= countNext == FULL_COUNT;
            wrState       <= wrEn ? WR_GRANT : WR_ACCEPT;
            bus.GntUpStr  <= wrEn;
            rdState       <= rdState == RD_REQ ? (bus.GntDnStr ? RD_BUBBLE : RD_REQ)
                                               : (countNext != '0 ? RD_REQ : RD_EMPTY);
            bus.ReqDnStr  <= rdState == RD_REQ ? !bus.GntDnStr : countNext != '0;
        end
    end

    always_ff @(posedge clk)
        if (wrEn)
            mem[wrPtr] <= bus.PacketIn;

    assign bus.PacketOut = mem[rdPtr];

    xy_route_decode #(
        .dataWidth(dataWidth),
        .dim      (dim)
    ) routeDecode (
        .packet(bus.PacketOut),
        .dirReq(headDir)
    );

    assign bus.DirReq = bus.ReqDnStr ? headDir : '0;

`ifdef LPB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.PktCount   <= '0;
            bus.FullCycles <= '0;
        end else begin
            if (wrEn && !(&bus.PktCount))
                bus.PktCount <= bus.PktCount + 16'd1;
            if (bus.UpStrFull && !(&bus.FullCycles))
                bus.FullCycles <= bus.FullCycles + 16'd1;
        end
    end
`else
    assign bus.PktCount   = '0;
    assign bus.FullCycles = '0;
`endif

endmodule

// File: tb/tb_local_port_buffer.sv
// tb_local_port_buffer: directed scenarios plus a randomized run against a queue-based model of the local-port buffer.
module tb_local_port_buffer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   errors = 0;
    int   fullSeen = 0;
    int   pktSeen = 0;
    logic [15:0] expFull;
    logic [15:0] expPkt;

    localparam logic [31:0] RT_PKT [5] = '{32'h0200_0000, 32'h0000_0000, 32'h3000_0000, 32'h0A00_0000, 32'hC300_0000};
    localparam logic [4:0]  RT_DIR [5] = '{5'b01000, 5'b00001, 5'b10000, 5'b00010, 5'b00100};

    local_port_buffer_if #(.dataWidth(32)) bus();

    local_port_buffer #(
        .dataWidth(32),
        .dim      (4),
        .DEPTH    (4),
        .ADDR_W   (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] route(input logic [31:0] p);
        int xHops = int'(p[30:28]);
        int yHops = int'(p[26:24]);
        if (xHops != 0) return p[31] ? 5'b00100 : 5'b10000;
        if (yHops != 0) return p[27] ? 5'b00010 : 5'b01000;
        return 5'b00001;
    endfunction

    // Sample point; FullCycles counts edges already taken with the buffer full
    task automatic tick();
        @(negedge clk);
        expFull = 16'(fullSeen);
        if (bus.UpStrFull === 1'b1) fullSeen++;
        if (bus.GntUpStr === 1'b1) pktSeen++;
        expPkt = 16'(pktSeen);
`ifndef LPB_STATS_EN
        expFull = 16'h0;
        expPkt = 16'h0;
`endif
    endtask

    task automatic do_reset();
        bus.ReqUpStr = 1'b0;
        bus.GntDnStr = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        fullSeen = 0;
        pktSeen = 0;
    endtask

    task automatic push(input logic [31:0] pkt);
        bus.PacketIn = pkt;
        bus.ReqUpStr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.GntUpStr === 1'b1) begin
                bus.ReqUpStr = 1'b0;
                return;
            end
        end
        tests++;
        errors++;
        $display("FAIL push_timeout: no GntUpStr within 20 cycles for %h", pkt);
        bus.ReqUpStr = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        @(negedge clk);
        tests++;
        if ({bus.GntUpStr, bus.UpStrFull, bus.ReqDnStr, bus.DirReq} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b, want 00000000", {bus.GntUpStr, bus.UpStrFull, bus.ReqDnStr, bus.DirReq});
        end
        tests++;
        if ({bus.PktCount, bus.FullCycles} !== 32'h0) begin
            errors++;
            $display("FAIL reset_counters: got %h, want 00000000", {bus.PktCount, bus.FullCycles});
        end
        reset = 1'b1;
        repeat (2) tick();
        tests++;
        if (bus.ReqDnStr !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_req: got %b, want 0", bus.ReqDnStr);
        end
    endtask

    task automatic test_single();
        int gnts = 0;
        do_reset();
        bus.PacketIn = 32'h9000_0041;
        bus.ReqUpStr = 1'b1;
        repeat (4) begin
            tick();
            if (bus.GntUpStr === 1'b1) begin
                gnts++;
                bus.ReqUpStr = 1'b0;
                tests++;
                if (bus.ReqDnStr !== 1'b1) begin
                    errors++;
                    $display("FAIL single_req: got %b, want 1", bus.ReqDnStr);
                end
                tests++;
                if (bus.PacketOut !== 32'h9000_0041) begin
                    errors++;
                    $display("FAIL single_packet: got %h, want 90000041", bus.PacketOut);
                end
                tests++;
                if (bus.DirReq !== 5'b00100) begin
                    errors++;
                    $display("FAIL single_dir: got %b, want 00100", bus.DirReq);
                end
            end
        end
        tests++;
        if (gnts != 1) begin
            errors++;
            $display("FAIL single_gnt_count: got %0d, want 1", gnts);
        end
        tests++;
        if (bus.PktCount !== expPkt) begin
            errors++;
            $display("FAIL single_pktcount: got %0d, want %0d", bus.PktCount, expPkt);
        end
        bus.GntDnStr = 1'b1;
        tick();
        bus.GntDnStr = 1'b0;
        tests++;
        if (bus.ReqDnStr !== 1'b0) begin
            errors++;
            $display("FAIL single_bubble: got %b, want 0", bus.ReqDnStr);
        end
        tick();
        tests++;
        if ({bus.ReqDnStr, bus.DirReq} !== 6'b0) begin
            errors++;
            $display("FAIL single_empty: got %b, want 000000", {bus.ReqDnStr, bus.DirReq});
        end
    endtask

    task automatic test_fill();
        logic [31:0] p [5];
        do_reset();
        for (int i = 0; i < 5; i++) p[i] = $urandom;
        for (int i = 0; i < 4; i++) push(p[i]);
        tests++;
        if (bus.UpStrFull !== 1'b1) begin
            errors++;
            $display("FAIL fill_full: got %b, want 1", bus.UpStrFull);
        end
        bus.PacketIn = p[4];
        bus.ReqUpStr = 1'b1;
        repeat (5) begin
            tick();
            tests++;
            if ({bus.GntUpStr, bus.UpStrFull} !== 2'b01) begin
                errors++;
                $display("FAIL fill_blocked: got gnt/full %b, want 01", {bus.GntUpStr, bus.UpStrFull});
            end
        end
        bus.GntDnStr = 1'b1;
        tick();
        bus.GntDnStr = 1'b0;
        tests++;
        if ({bus.UpStrFull, bus.ReqDnStr, bus.GntUpStr} !== 3'b000) begin
            errors++;
            $display("FAIL fill_pop: got full/req/gnt %b, want 000", {bus.UpStrFull, bus.ReqDnStr, bus.GntUpStr});
        end
        tick();
        bus.ReqUpStr = 1'b0;
        tests++;
        if (bus.GntUpStr !== 1'b1) begin
            errors++;
            $display("FAIL fill_late_gnt: got %b, want 1", bus.GntUpStr);
        end
        tests++;
        if (bus.FullCycles !== expFull) begin
            errors++;
            $display("FAIL fill_fullcycles: got %0d, want %0d", bus.FullCycles, expFull);
        end
        tests++;
        if (bus.ReqDnStr !== 1'b1 || bus.PacketOut !== p[1]) begin
            errors++;
            $display("FAIL fill_head: got req %b pkt %h, want 1 %h", bus.ReqDnStr, bus.PacketOut, p[1]);
        end
    endtask

    task automatic test_order();
        logic [31:0] p [3];
        logic [6:0]  pat = 7'b1010100;
        int k = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            p[i] = $urandom;
            push(p[i]);
        end
        bus.GntDnStr = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            tests++;
            if (bus.ReqDnStr !== pat[6-i]) begin
                errors++;
                $display("FAIL order_req[%0d]: got %b, want %b", i, bus.ReqDnStr, pat[6-i]);
            end
            if (bus.ReqDnStr === 1'b1) begin
                tests++;
                if (k > 2 || bus.PacketOut !== p[k]) begin
                    errors++;
                    $display("FAIL order_packet[%0d]: got %h, want %h", k, bus.PacketOut, k > 2 ? 32'h0 : p[k]);
                end
                k++;
            end
        end
        bus.GntDnStr = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [31:0] a = $urandom;
        logic [31:0] b = $urandom;
        logic [31:0] c = $urandom;
        do_reset();
        push(a);
        push(b);
        tick();
        bus.PacketIn = c;
        bus.ReqUpStr = 1'b1;
        bus.GntDnStr = 1'b1;
        tick();
        bus.ReqUpStr = 1'b0;
        bus.GntDnStr = 1'b0;
        tests++;
        if ({bus.GntUpStr, bus.ReqDnStr, bus.UpStrFull} !== 3'b100) begin
            errors++;
            $display("FAIL sim_edge: got gnt/req/full %b, want 100", {bus.GntUpStr, bus.ReqDnStr, bus.UpStrFull});
        end
        tick();
        tests++;
        if (bus.ReqDnStr !== 1'b1 || bus.PacketOut !== b) begin
            errors++;
            $display("FAIL sim_head: got req %b pkt %h, want 1 %h", bus.ReqDnStr, bus.PacketOut, b);
        end
        bus.GntDnStr = 1'b1;
        tick();
        bus.GntDnStr = 1'b0;
        tick();
        tests++;
        if (bus.ReqDnStr !== 1'b1 || bus.PacketOut !== c) begin
            errors++;
            $display("FAIL sim_tail: got req %b pkt %h, want 1 %h", bus.ReqDnStr, bus.PacketOut, c);
        end
        bus.GntDnStr = 1'b1;
        tick();
        bus.GntDnStr = 1'b0;
        tick();
        tests++;
        if (bus.ReqDnStr !== 1'b0) begin
            errors++;
            $display("FAIL sim_count: got req %b after two pops, want 0", bus.ReqDnStr);
        end
    endtask

    task automatic test_routing();
        for (int i = 0; i < 5; i++) begin
            do_reset();
            push(RT_PKT[i] | ($urandom & 32'h00FF_FFFF));
            tests++;
            if (bus.DirReq !== RT_DIR[i]) begin
                errors++;
                $display("FAIL route[%0d]: got %b, want %b", i, bus.DirReq, RT_DIR[i]);
            end
            bus.GntDnStr = 1'b1;
            tick();
            bus.GntDnStr = 1'b0;
            tests++;
            if (bus.DirReq !== 5'b0) begin
                errors++;
                $display("FAIL route_gated[%0d]: got %b, want 00000", i, bus.DirReq);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] fresh = $urandom;
        do_reset();
        for (int i = 0; i < 3; i++) push($urandom);
        bus.PacketIn = $urandom;
        bus.ReqUpStr = 1'b1;
        #1 reset = 1'b0;
        #1;
        tests++;
        if ({bus.GntUpStr, bus.ReqDnStr, bus.UpStrFull, bus.DirReq} !== 8'h00) begin
            errors++;
            $display("FAIL midreset_async: got %b, want 00000000", {bus.GntUpStr, bus.ReqDnStr, bus.UpStrFull, bus.DirReq});
        end
        tick();
        tests++;
        if ({bus.GntUpStr, bus.ReqDnStr, bus.UpStrFull, bus.PktCount, bus.FullCycles} !== 35'h0) begin
            errors++;
            $display("FAIL midreset_sample: got %h, want 0", {bus.GntUpStr, bus.ReqDnStr, bus.UpStrFull, bus.PktCount, bus.FullCycles});
        end
        bus.ReqUpStr = 1'b0;
        reset = 1'b1;
        fullSeen = 0;
        pktSeen = 0;
        repeat (3) begin
            tick();
            tests++;
            if (bus.ReqDnStr !== 1'b0) begin
                errors++;
                $display("FAIL midreset_stale_req: got %b, want 0", bus.ReqDnStr);
            end
        end
        push(fresh);
        tests++;
        if (bus.ReqDnStr !== 1'b1 || bus.PacketOut !== fresh) begin
            errors++;
            $display("FAIL midreset_fresh: got req %b pkt %h, want 1 %h", bus.ReqDnStr, bus.PacketOut, fresh);
        end
    endtask

    // Model: a packet enters on an observed grant, leaves on a granted request;
    // a request is granted only if the previous cycle was not a grant and the queue was not full;
    // ReqDnStr shows a non-empty queue except right after a pop
    task automatic test_random();
        logic [31:0] q [$];
        logic [31:0] cur = '0;
        logic prevReq = 1'b0;
        logic prevGnt = 1'b0;
        logic popped = 1'b0;
        logic gntExp;
        logic reqExp;
        int prevSize = 0;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            tick();
            gntExp = prevReq && !prevGnt && prevSize < 4;
            tests++;
            if (bus.GntUpStr !== gntExp) begin
                errors++;
                $display("FAIL rand_gnt@%0d: got %b, want %b", n, bus.GntUpStr, gntExp);
            end
            if (bus.GntUpStr === 1'b1) q.push_back(cur);
            tests++;
            if (bus.UpStrFull !== (q.size() == 4)) begin
                errors++;
                $display("FAIL rand_full@%0d: got %b, want %b", n, bus.UpStrFull, q.size() == 4);
            end
            reqExp = q.size() > 0 && !popped;
            tests++;
            if (bus.ReqDnStr !== reqExp) begin
                errors++;
                $display("FAIL rand_req@%0d: got %b, want %b", n, bus.ReqDnStr, reqExp);
            end
            if (bus.ReqDnStr === 1'b1 && q.size() > 0) begin
                tests++;
                if (bus.PacketOut !== q[0] || bus.DirReq !== route(q[0])) begin
                    errors++;
                    $display("FAIL rand_head@%0d: got %h/%b, want %h/%b", n, bus.PacketOut, bus.DirReq, q[0], route(q[0]));
                end
            end else begin
                tests++;
                if (bus.DirReq !== 5'b0) begin
                    errors++;
                    $display("FAIL rand_dir_idle@%0d: got %b, want 00000", n, bus.DirReq);
                end
            end
            tests++;
            if (bus.PktCount !== expPkt || bus.FullCycles !== expFull) begin
                errors++;
                $display("FAIL rand_stats@%0d: got %0d/%0d, want %0d/%0d", n, bus.PktCount, bus.FullCycles, expPkt, expFull);
            end
            prevGnt = bus.GntUpStr;
            prevSize = q.size();
            if (bus.GntUpStr === 1'b1) bus.ReqUpStr = 1'b0;
            if (!bus.ReqUpStr && $urandom_range(1, 0) == 1) begin
                cur = $urandom;
                if ($urandom_range(2, 0) == 0) cur[30:28] = 3'b0;
                if ($urandom_range(2, 0) == 0) cur[26:24] = 3'b0;
                bus.PacketIn = cur;
                bus.ReqUpStr = 1'b1;
            end
            prevReq = bus.ReqUpStr;
            bus.GntDnStr = n < 200 ? ($urandom_range(3, 0) == 0) : ($urandom_range(3, 0) != 0);
            popped = bus.GntDnStr && bus.ReqDnStr === 1'b1;
            if (popped) void'(q.pop_front());
        end
        bus.ReqUpStr = 1'b0;
        bus.GntDnStr = 1'b0;
    endtask

    initial begin
        bus.ReqUpStr = 1'b0;
        bus.GntDnStr = 1'b0;
        bus.PacketIn = '0;
        test_reset();
        test_single();
        test_fill();
        test_order();
        test_simultaneous();
        test_routing();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
